// File: rtl/fifo_enq_arbiter.sv
// fifo_enq_arbiter
//   Shares the single enq method of a downstream FIFO between two producer
//   clients using round-robin arbitration with bounded bursts. Each beat
//   forwarded downstream is tagged with its source id in the MSB.
//
// Handshake: a client may assert cN_enq__ENA only in a cycle where
//   cN_enq__RDY is high; the beat is accepted in that same cycle. RDY is
//   derived from requests, registered state and out_enq__RDY only, never
//   from any ENA, so there is no combinational ENA->RDY loop. cN_req is a
//   level "I have a beat" and must not depend on cN_enq__RDY.
//
// Ports:
//   CLK, nRST                 clock, synchronous active-low reset
//   cN_req                    client N has a beat pending
//   cN_enq__ENA / cN_enq_v    client N enq fire and payload
//   cN_enq__RDY               client N may fire this cycle
//   out_enq__RDY              downstream FIFO can accept
//   out_enq__ENA / out_enq_v  downstream enq, {source id, payload}
//   count0 / count1           saturating accepted-beat counters
//   err                       sticky protocol-violation flag
module fifo_enq_arbiter #(
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             c0_req,
  input  logic             c0_enq__ENA,
  input  logic [WIDTH-1:0] c0_enq_v,
  output logic             c0_enq__RDY,
  input  logic             c1_req,
  input  logic             c1_enq__ENA,
  input  logic [WIDTH-1:0] c1_enq_v,
  output logic             c1_enq__RDY,
  input  logic             out_enq__RDY,
  output logic             out_enq__ENA,
  output logic [WIDTH:0]   out_enq_v,
  output logic [CNT_W-1:0] count0,
  output logic [CNT_W-1:0] count1,
  output logic             err
);

  localparam int BC_W = $clog2(MAX_BURST + 1);

  logic             r_cur;
  logic             r_prio;
  logic [BC_W-1:0]  r_burst_cnt;
  logic [CNT_W-1:0] r_count0;
  logic [CNT_W-1:0] r_count1;
  logic             r_err;

  logic [1:0]       w_req;
  logic             w_grant_valid;
  logic             w_cont;
  logic             w_g;
  logic             w_fire0;
  logic             w_fire1;
  logic             w_viol;

  assign w_req         = {c1_req, c0_req};
  assign w_grant_valid = |w_req;

  // A burst continues only while its owner keeps requesting and has not
  // yet used its MAX_BURST beats; burst_cnt==0 means no burst in progress.
  always_comb begin
    w_cont = 1'b0;
    w_g    = 1'b0;
    if (w_req[r_cur] && (r_burst_cnt != '0) &&
        (r_burst_cnt < BC_W'(MAX_BURST))) begin
      w_cont = 1'b1;
    end
    if (w_cont) begin
      w_g = r_cur;
    end else if (w_req[r_prio]) begin
      w_g = r_prio;
    end else begin
      w_g = ~r_prio;
    end
  end

  assign c0_enq__RDY = out_enq__RDY & w_grant_valid & ~w_g;
  assign c1_enq__RDY = out_enq__RDY & w_grant_valid &  w_g;

  // An ENA without the matching RDY is dropped here, so it never reaches
  // the FIFO or the counters; it only raises the sticky error.
  assign w_fire0 = c0_enq__ENA & c0_enq__RDY;
  assign w_fire1 = c1_enq__ENA & c1_enq__RDY;
  assign w_viol  = (c0_enq__ENA & ~c0_enq__RDY) | (c1_enq__ENA & ~c1_enq__RDY);

  assign out_enq__ENA = w_fire0 | w_fire1;
  assign out_enq_v    = {w_g, (w_g ? c1_enq_v : c0_enq_v)};

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_cur       <= 1'b0;
      r_prio      <= 1'b0;
      r_burst_cnt <= '0;
      r_count0    <= '0;
      r_count1    <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_viol) begin
        r_err <= 1'b1;
      end
      if (out_enq__ENA) begin
        // w_cont implies the grant is the current burst owner.
        if (w_cont) begin
          r_burst_cnt <= r_burst_cnt + BC_W'(1);
        end else begin
          r_cur       <= w_g;
          r_burst_cnt <= BC_W'(1);
        end
        r_prio <= ~w_g;
        if (!w_g && (r_count0 != '1)) begin
          r_count0 <= r_count0 + CNT_W'(1);
        end
        if (w_g && (r_count1 != '1)) begin
          r_count1 <= r_count1 + CNT_W'(1);
        end
      end else if (!w_req[r_cur]) begin
        // Owner dropped its request: the burst is over. A downstream stall
        // with the owner still requesting keeps the burst alive.
        r_burst_cnt <= '0;
      end
    end
  end

  assign count0 = r_count0;
  assign count1 = r_count1;
  assign err    = r_err;

endmodule

// File: tb/tb_fifo_enq_arbiter.sv
module tb_fifo_enq_arbiter;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  // ---------------- shared stimulus ----------------
  logic        c0_req, c1_req, out_rdy, c1_bad;
  logic [31:0] c0_v, c1_v;

  // Three instances: b2 (MAX_BURST=2), b1 (MAX_BURST=1), b4 (MAX_BURST=4, CNT_W=4)
  logic        rdy0_b2, rdy1_b2, ena_b2, err_b2, c0_ena_b2, c1_ena_b2;
  logic [32:0] v_b2;
  logic [15:0] cnt0_b2, cnt1_b2;
  logic        rdy0_b1, rdy1_b1, ena_b1, err_b1, c0_ena_b1, c1_ena_b1;
  logic [32:0] v_b1;
  logic [15:0] cnt0_b1, cnt1_b1;
  logic        rdy0_b4, rdy1_b4, ena_b4, err_b4, c0_ena_b4, c1_ena_b4;
  logic [32:0] v_b4;
  logic [3:0]  cnt0_b4, cnt1_b4;

  // Well-behaved clients fire whenever they request and are ready;
  // c1_bad injects an illegal client-1 fire.
  assign c0_ena_b2 = c0_req & rdy0_b2;
  assign c1_ena_b2 = (c1_req & rdy1_b2) | c1_bad;
  assign c0_ena_b1 = c0_req & rdy0_b1;
  assign c1_ena_b1 = (c1_req & rdy1_b1) | c1_bad;
  assign c0_ena_b4 = c0_req & rdy0_b4;
  assign c1_ena_b4 = (c1_req & rdy1_b4) | c1_bad;

  fifo_enq_arbiter #(.WIDTH(32), .MAX_BURST(2), .CNT_W(16)) u_b2 (
    .CLK(CLK), .nRST(nRST),
    .c0_req(c0_req), .c0_enq__ENA(c0_ena_b2), .c0_enq_v(c0_v), .c0_enq__RDY(rdy0_b2),
    .c1_req(c1_req), .c1_enq__ENA(c1_ena_b2), .c1_enq_v(c1_v), .c1_enq__RDY(rdy1_b2),
    .out_enq__RDY(out_rdy), .out_enq__ENA(ena_b2), .out_enq_v(v_b2),
    .count0(cnt0_b2), .count1(cnt1_b2), .err(err_b2));

  fifo_enq_arbiter #(.WIDTH(32), .MAX_BURST(1), .CNT_W(16)) u_b1 (
    .CLK(CLK), .nRST(nRST),
    .c0_req(c0_req), .c0_enq__ENA(c0_ena_b1), .c0_enq_v(c0_v), .c0_enq__RDY(rdy0_b1),
    .c1_req(c1_req), .c1_enq__ENA(c1_ena_b1), .c1_enq_v(c1_v), .c1_enq__RDY(rdy1_b1),
    .out_enq__RDY(out_rdy), .out_enq__ENA(ena_b1), .out_enq_v(v_b1),
    .count0(cnt0_b1), .count1(cnt1_b1), .err(err_b1));

  fifo_enq_arbiter #(.WIDTH(32), .MAX_BURST(4), .CNT_W(4)) u_b4 (
    .CLK(CLK), .nRST(nRST),
    .c0_req(c0_req), .c0_enq__ENA(c0_ena_b4), .c0_enq_v(c0_v), .c0_enq__RDY(rdy0_b4),
    .c1_req(c1_req), .c1_enq__ENA(c1_ena_b4), .c1_enq_v(c1_v), .c1_enq__RDY(rdy1_b4),
    .out_enq__RDY(out_rdy), .out_enq__ENA(ena_b4), .out_enq_v(v_b4),
    .count0(cnt0_b4), .count1(cnt1_b4), .err(err_b4));

  // ---------------- scoreboard ----------------
  // Entry per driven cycle: {expected ENA, expected out_enq_v}.
  logic [33:0] exp_q[$];
  logic [33:0] m_e;
  int          n_vec = 0;
  int          n_err = 0;
  logic        mon_en = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic        sel_ena;
  logic [32:0] sel_v;

  always_comb begin
    sel_ena = ena_b2;
    sel_v   = v_b2;
    case (sel)
      2'd1: begin sel_ena = ena_b1; sel_v = v_b1; end
      2'd2: begin sel_ena = ena_b4; sel_v = v_b4; end
      default: ;
    endcase
  end

  always @(negedge CLK) begin
    if (mon_en) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_underflow: got ena=%0b v=%h, nothing expected", sel_ena, sel_v);
      end else begin
        m_e = exp_q.pop_front();
        if (sel_ena !== m_e[33]) begin
          n_err++;
          $display("FAIL beat_ena: got %0b expected %0b (t=%0t)", sel_ena, m_e[33], $time);
        end else if (m_e[33] && (sel_v !== m_e[32:0])) begin
          n_err++;
          $display("FAIL beat_data: got %h expected %h (t=%0t)", sel_v, m_e[32:0], $time);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r0, input logic r1, input logic rdy, input logic bad,
                       input logic [31:0] p0, input logic [31:0] p1,
                       input logic e_ena, input logic e_id);
    c0_req  = r0;
    c1_req  = r1;
    out_rdy = rdy;
    c1_bad  = bad;
    c0_v    = p0;
    c1_v    = p1;
    exp_q.push_back({e_ena, e_id, (e_id ? p1 : p0)});
    mon_en = 1'b1;
    @(posedge CLK);
    #1;
    mon_en = 1'b0;
  endtask

  task automatic apply_reset();
    mon_en  = 1'b0;
    nRST    = 1'b0;
    c0_req  = 1'b0;
    c1_req  = 1'b0;
    c1_bad  = 1'b0;
    out_rdy = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    nRST = 1'b0; c0_req = 1'b1; c1_req = 1'b1; c1_bad = 1'b0; out_rdy = 1'b1;
    c0_v = 32'hA0; c1_v = 32'hB0;
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
    @(negedge CLK);
    n_vec++; if (cnt0_b2 !== 16'd0) begin n_err++; $display("FAIL rst_count0: got %0d expected 0", cnt0_b2); end
    n_vec++; if (cnt1_b2 !== 16'd0) begin n_err++; $display("FAIL rst_count1: got %0d expected 0", cnt1_b2); end
    n_vec++; if (err_b2 !== 1'b0) begin n_err++; $display("FAIL rst_err: got %0b expected 0", err_b2); end
    n_vec++; if (rdy0_b2 !== 1'b1) begin n_err++; $display("FAIL rst_rdy0: got %0b expected 1", rdy0_b2); end
    n_vec++; if (rdy1_b2 !== 1'b0) begin n_err++; $display("FAIL rst_rdy1: got %0b expected 0", rdy1_b2); end
    n_vec++; if (cnt0_b4 !== 4'd0) begin n_err++; $display("FAIL rst_count0_b4: got %0d expected 0", cnt0_b4); end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_burst2();
    logic ids [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    sel = 2'd0;
    apply_reset();
    for (int i = 0; i < 8; i++)
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'hA0 + i, 32'hB0 + i, 1'b1, ids[i]);
    n_vec++; if (cnt0_b2 !== 16'd4) begin n_err++; $display("FAIL b2_count0: got %0d expected 4", cnt0_b2); end
    n_vec++; if (cnt1_b2 !== 16'd4) begin n_err++; $display("FAIL b2_count1: got %0d expected 4", cnt1_b2); end
  endtask

  task automatic test_round_robin();
    sel = 2'd1;
    apply_reset();
    for (int i = 0; i < 4; i++)
      drive(1'b1, 1'b1, 1'b1, 1'b0, $urandom, $urandom, 1'b1, i[0]);
    for (int i = 0; i < 6; i++)
      drive(1'b0, 1'b1, 1'b1, 1'b0, $urandom, 32'hBB, 1'b1, 1'b1);
    n_vec++; if (cnt0_b1 !== 16'd2) begin n_err++; $display("FAIL b1_count0: got %0d expected 2", cnt0_b1); end
    n_vec++; if (cnt1_b1 !== 16'd8) begin n_err++; $display("FAIL b1_count1: got %0d expected 8", cnt1_b1); end
  endtask

  task automatic test_stall();
    sel = 2'd2;
    apply_reset();
    for (int i = 0; i < 2; i++)
      drive(1'b1, 1'b1, 1'b1, 1'b0, $urandom, $urandom, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, $urandom, $urandom, 1'b0, 1'b0);
      n_vec++;
      if ((rdy0_b4 | rdy1_b4) !== 1'b0) begin
        n_err++; $display("FAIL stall_rdy: got rdy0=%0b rdy1=%0b expected both 0", rdy0_b4, rdy1_b4);
      end
    end
    for (int i = 0; i < 2; i++)
      drive(1'b1, 1'b1, 1'b1, 1'b0, $urandom, $urandom, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, $urandom, $urandom, 1'b1, 1'b1);
    n_vec++; if (cnt0_b4 !== 4'd4) begin n_err++; $display("FAIL stall_count0: got %0d expected 4", cnt0_b4); end
  endtask

  task automatic test_protocol_error();
    sel = 2'd0;
    apply_reset();
    drive(1'b0, 1'b0, 1'b1, 1'b1, $urandom, $urandom, 1'b0, 1'b0);
    n_vec++; if (err_b2 !== 1'b1) begin n_err++; $display("FAIL perr_set: got %0b expected 1", err_b2); end
    n_vec++; if (cnt1_b2 !== 16'd0) begin n_err++; $display("FAIL perr_count1: got %0d expected 0", cnt1_b2); end
    for (int i = 0; i < 2; i++)
      drive(1'b0, 1'b0, 1'b1, 1'b0, $urandom, $urandom, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, $urandom, $urandom, 1'b1, 1'b0);
    n_vec++; if (err_b2 !== 1'b1) begin n_err++; $display("FAIL perr_sticky: got %0b expected 1", err_b2); end
    n_vec++; if (cnt0_b2 !== 16'd1) begin n_err++; $display("FAIL perr_count0: got %0d expected 1", cnt0_b2); end
    apply_reset();
    n_vec++; if (err_b2 !== 1'b0) begin n_err++; $display("FAIL perr_clear: got %0b expected 0", err_b2); end
  endtask

  task automatic test_saturation();
    sel = 2'd2;
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, $urandom_range(0, 32'hFFFF), $urandom, 1'b1, 1'b0);
      if (i == 14) begin
        n_vec++; if (cnt0_b4 !== 4'hF) begin n_err++; $display("FAIL sat_reach: got %h expected f", cnt0_b4); end
      end
    end
    n_vec++; if (cnt0_b4 !== 4'hF) begin n_err++; $display("FAIL sat_hold: got %h expected f", cnt0_b4); end
    n_vec++; if (cnt1_b4 !== 4'h0) begin n_err++; $display("FAIL sat_count1: got %h expected 0", cnt1_b4); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    nRST = 1'b0; c0_req = 1'b0; c1_req = 1'b0; c1_bad = 1'b0; out_rdy = 1'b0;
    c0_v = '0; c1_v = '0;
    @(posedge CLK);
    #1;
    test_reset();
    test_burst2();
    test_round_robin();
    test_stall();
    test_protocol_error();
    test_saturation();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL sb_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
